block_processor: RTL and testbench
==================================

# block_processor

- Worker stage directly downstream of `main_CU` in the coprocessor.
- Each of the `p` instances computes one element of C = A·B:
  - accepts a row/column index pair from `main_CU`,
  - acquires the shared memory bus through the grant arbiter,
  - streams row `row` of A and column `col` of B and accumulates their dot product,
  - writes C[row][col] back, then raises result-ready to `main_CU`.

## Interface

Parameters:
- `DATA_WIDTH`, 32, matrix element and accumulator width
- `ADDR_WIDTH`, 16, memory word-address width
- `INDEX_WIDTH`, 8, width of row/column indexes and of dimension N

Ports:
- `i_Clock`  in  1  single clock, rising edge
- `i_Reset_n`  in  1  reset, asynchronous, active-low
- `i_Indexes_Ready`  in  1  this processor's bit of `main_CU` `o_Indexes_Ready`
- `i_Row_Index`  in  INDEX_WIDTH  row of A
- `i_Column_Index`  in  INDEX_WIDTH  column of B
- `i_N`  in  INDEX_WIDTH  square matrix dimension
- `i_A_Base`, `i_B_Base`, `i_C_Base`  in  ADDR_WIDTH each  row-major base addresses
- `o_Indexes_Received`  out  1  one-cycle acknowledge of a latched index pair
- `o_Result_Ready`  out  1  level; C element written
- `o_Grant_Request`  out  1  memory bus request
- `i_Grant`  in  1  memory bus grant
- `o_Mem_Address`  out  ADDR_WIDTH  word address
- `o_Mem_Read`  out  1  read strobe; data valid on `i_Mem_Read_Data` the following cycle
- `i_Mem_Read_Data`  in  DATA_WIDTH  read data
- `o_Mem_Write`  out  1  write strobe; write commits at the edge ending the cycle
- `o_Mem_Write_Data`  out  DATA_WIDTH  write data

## Operation

States: IDLE, REQ, READ_A, READ_B, MAC, WRITE.

- **IDLE:**
  - When `i_Indexes_Ready`=1: latch row, col, N and the three bases; clear `acc` and `k`; clear `o_Result_Ready`; pulse `o_Indexes_Received` for the next cycle; go to REQ.
  - `i_Indexes_Ready` is ignored in every other state. `main_CU` holds it until it sees `o_Indexes_Received`.
- **REQ:**
  - `o_Grant_Request`=1.
  - If `i_Grant`=1: go to READ_A, or to WRITE if N=0.
- **READ_A:**
  - Address = A_Base + row·N + k, `o_Mem_Read`=1.
  - Go to READ_B.
- **READ_B:**
  - Capture `a` ← `i_Mem_Read_Data`.
  - Address = B_Base + k·N + col, `o_Mem_Read`=1.
  - Go to MAC.
- **MAC:**
  - `acc` ← `acc` + `a`·`i_Mem_Read_Data`.
  - If k=N−1, go to WRITE; else k ← k+1 and go to READ_A.
- **WRITE:**
  - Address = C_Base + row·N + col, `o_Mem_Write`=1, `o_Mem_Write_Data`=`acc`.
  - On the edge leaving WRITE: `o_Result_Ready` ← 1 and go to IDLE.
- **Outputs:**
  - `o_Grant_Request`=1 in every state except IDLE.
  - Memory outputs are decoded from registered state. Address is 0 and strobes are 0 outside the access states.
- **Arithmetic:**
  - Product is truncated to its low DATA_WIDTH bits; `acc` wraps modulo 2^DATA_WIDTH.
  - Address sums and products wrap modulo 2^ADDR_WIDTH.
  - Unsigned throughout.
- **Grant loss:**
  - In READ_A, READ_B or MAC with `i_Grant`=0: `o_Mem_Read` is forced to 0, there is no capture or accumulate, `k` is unchanged, and the next state is READ_A (the current k is re-read).
  - In WRITE with `i_Grant`=0: `o_Mem_Write` is forced to 0 and the state stays WRITE.
- **`o_Result_Ready`:** stays 1 through IDLE until the next index pair is latched.

## Timing

- **Reset:** all outputs 0, state IDLE, `acc`/`k`/`a` 0.
- **Reset mid-operation:** aborts immediately and asynchronously. Request and strobes drop with reset, no write is issued, and no partial result is kept.
- **Latency, grant continuously high:** edge e0 samples `i_Indexes_Ready`; `o_Result_Ready` rises at edge e(3N+2).
  - N=2 gives 8 edges.
  - N=0 gives 2 edges (a write of 0).
- **Throughput:** 3 cycles per k, plus 1 write cycle; bus held for 3N+1 granted cycles.
- **Index acknowledge:** `o_Indexes_Received` is high exactly one cycle, the cycle after e0.
- **Back-to-back jobs:** a new job can be latched the cycle `o_Result_Ready` rises, since the block is already in IDLE. Latching the new job clears `o_Result_Ready` one edge later.

## Test plan

- **Basic product:**
  - Memory: A=[[1,2],[3,4]] at 0, B=[[5,6],[7,8]] at 4, C base 8, N=2; row=1, col=0.
  - Expect: write of 43 to address 10; `o_Result_Ready` at e8; `o_Indexes_Received` a single pulse; reads at addresses 2, 4, 3, 6 in that order.
- **N=0:** expect a single write of 0 to C_Base+0, with `o_Result_Ready` at e2 and no reads.
- **Grant withdrawn for 3 cycles in READ_B at k=1 (basic-product setup):**
  - k=1 is re-read from READ_A.
  - Result is still 43; total latency 8+3+1 edges.
  - No read strobe while ungranted.
- **Overflow, DATA_WIDTH=32, N=1:**
  - A=0xFFFF_FFFF, B=2; expect write 0xFFFF_FFFE.
- **Reset asserted in MAC, then a fresh job:**
  - No write occurs; outputs are 0 during reset.
  - The fresh job completes correctly.
- **`i_Indexes_Ready` held high across two jobs:**
  - The second pair is latched only after return to IDLE.
  - `o_Result_Ready` falls one edge after the second latch.

Source files
------------

// File: rtl/block_processor_if.sv
// Index handshake with main_CU plus the arbitrated memory bus of one
// block_processor. Signal names are written from the processor's side.
interface block_processor_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int INDEX_WIDTH = 8
);
  // main_CU job handshake
  logic                   i_Indexes_Ready;
  logic [INDEX_WIDTH-1:0] i_Row_Index;
  logic [INDEX_WIDTH-1:0] i_Column_Index;
  logic [INDEX_WIDTH-1:0] i_N;
  logic [ADDR_WIDTH-1:0]  i_A_Base;
  logic [ADDR_WIDTH-1:0]  i_B_Base;
  logic [ADDR_WIDTH-1:0]  i_C_Base;
  logic                   o_Indexes_Received;
  logic                   o_Result_Ready;
  // shared memory bus
  logic                   o_Grant_Request;
  logic                   i_Grant;
  logic [ADDR_WIDTH-1:0]  o_Mem_Address;
  logic                   o_Mem_Read;
  logic [DATA_WIDTH-1:0]  i_Mem_Read_Data;
  logic                   o_Mem_Write;
  logic [DATA_WIDTH-1:0]  o_Mem_Write_Data;

  // processor side
  modport master (
    input  i_Indexes_Ready, i_Row_Index, i_Column_Index, i_N,
           i_A_Base, i_B_Base, i_C_Base, i_Grant, i_Mem_Read_Data,
    output o_Indexes_Received, o_Result_Ready, o_Grant_Request,
           o_Mem_Address, o_Mem_Read, o_Mem_Write, o_Mem_Write_Data
  );

  // main_CU / arbiter / memory side
  modport slave (
    output i_Indexes_Ready, i_Row_Index, i_Column_Index, i_N,
           i_A_Base, i_B_Base, i_C_Base, i_Grant, i_Mem_Read_Data,
    input  o_Indexes_Received, o_Result_Ready, o_Grant_Request,
           o_Mem_Address, o_Mem_Read, o_Mem_Write, o_Mem_Write_Data
  );
endinterface

// File: rtl/block_processor.sv
// One dot-product worker: latches (row, col), streams A[row][k] and
// B[k][col] over the shared bus, accumulates, writes C[row][col].
module block_processor #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int INDEX_WIDTH = 8
) (
  input logic             i_Clock,
  input logic             i_Reset_n,
  block_processor_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ, READ_A, READ_B, MAC, WRITE} state_t;

  state_t                 state, state_nxt;
  logic [INDEX_WIDTH-1:0] row, col, n, k;
  logic [ADDR_WIDTH-1:0]  a_base, b_base, c_base;
  logic [DATA_WIDTH-1:0]  acc, a;
  logic                   idx_rcvd, res_rdy;

  // address arithmetic wraps at ADDR_WIDTH
  logic [ADDR_WIDTH-1:0]  row_a, col_a, n_a, k_a, addr_a, addr_b, addr_c;
  logic                   last_k, gnt;

  assign gnt    = bus.i_Grant;
  assign row_a  = ADDR_WIDTH'(row);
  assign col_a  = ADDR_WIDTH'(col);
  assign n_a    = ADDR_WIDTH'(n);
  assign k_a    = ADDR_WIDTH'(k);
  assign addr_a = a_base + row_a * n_a + k_a;
  assign addr_b = b_base + k_a * n_a + col_a;
  assign addr_c = c_base + row_a * n_a + col_a;
  assign last_k = (k == n - INDEX_WIDTH'(1));

  assign bus.o_Indexes_Received = idx_rcvd;
  assign bus.o_Result_Ready     = res_rdy;

  // state register
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // next state; losing the grant mid-stream restarts the current k at READ_A
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (bus.i_Indexes_Ready) state_nxt = REQ;
      REQ:    if (gnt) state_nxt = (n == '0) ? WRITE : READ_A;
      READ_A: state_nxt = gnt ? READ_B : READ_A;
      READ_B: state_nxt = gnt ? MAC : READ_A;
      MAC:    state_nxt = (gnt && last_k) ? WRITE : READ_A;
      WRITE:  if (gnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // bus outputs decoded from registered state; strobes gated by grant
  always_comb begin
    bus.o_Grant_Request  = (state != IDLE);
    bus.o_Mem_Address    = '0;
    bus.o_Mem_Read       = 1'b0;
    bus.o_Mem_Write      = 1'b0;
    bus.o_Mem_Write_Data = '0;
    case (state)
      READ_A: begin
        bus.o_Mem_Address = addr_a;
        bus.o_Mem_Read    = gnt;
      end
      READ_B: begin
        bus.o_Mem_Address = addr_b;
        bus.o_Mem_Read    = gnt;
      end
      WRITE: begin
        bus.o_Mem_Address    = addr_c;
        bus.o_Mem_Write      = gnt;
        bus.o_Mem_Write_Data = acc;
      end
      default: ;
    endcase
  end

  // job latch, operand capture, accumulate and completion flags
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      row <= '0; col <= '0; n <= '0; k <= '0;
      a_base <= '0; b_base <= '0; c_base <= '0;
      acc <= '0; a <= '0;
      idx_rcvd <= 1'b0; res_rdy <= 1'b0;
    end else begin
      idx_rcvd <= 1'b0;
      case (state)
        IDLE: if (bus.i_Indexes_Ready) begin
          row      <= bus.i_Row_Index;
          col      <= bus.i_Column_Index;
          n        <= bus.i_N;
          a_base   <= bus.i_A_Base;
          b_base   <= bus.i_B_Base;
          c_base   <= bus.i_C_Base;
          acc      <= '0;
          k        <= '0;
          idx_rcvd <= 1'b1;
          res_rdy  <= 1'b0;
        end
        READ_B: if (gnt) a <= bus.i_Mem_Read_Data;
        MAC: if (gnt) begin
          acc <= acc + a * bus.i_Mem_Read_Data;
          if (!last_k) k <= k + INDEX_WIDTH'(1);
        end
        WRITE: if (gnt) res_rdy <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_block_processor.sv
// Directed bench for block_processor with a 32-word memory model.
module tb_block_processor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  block_processor_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .INDEX_WIDTH(8)) bus();

  block_processor #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .INDEX_WIDTH(8)) dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .bus       (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // memory model: one-cycle read latency, write commits at the edge
  logic [31:0] mem [0:31];
  int rd_q[$];
  int wr_a[$];
  logic [31:0] wr_d[$];
  int bad_rd = 0;

  always @(posedge clk) begin
    if (bus.o_Mem_Read) begin
      bus.i_Mem_Read_Data <= mem[bus.o_Mem_Address[4:0]];
      rd_q.push_back(int'(bus.o_Mem_Address));
      if (!bus.i_Grant) bad_rd++;
    end
    if (bus.o_Mem_Write) begin
      mem[bus.o_Mem_Address[4:0]] <= bus.o_Mem_Write_Data;
      wr_a.push_back(int'(bus.o_Mem_Address));
      wr_d.push_back(bus.o_Mem_Write_Data);
    end
  end

  task automatic clear_log();
    rd_q.delete(); wr_a.delete(); wr_d.delete(); bad_rd = 0;
  endtask

  task automatic set_job(input int r, input int c, input int n,
                         input int ab, input int bb, input int cb);
    bus.i_Row_Index    = 8'(r);
    bus.i_Column_Index = 8'(c);
    bus.i_N            = 8'(n);
    bus.i_A_Base       = 16'(ab);
    bus.i_B_Base       = 16'(bb);
    bus.i_C_Base       = 16'(cb);
  endtask

  // runs one job with the handshake dropped after e0; lat = edges e0..result
  task automatic run_job(input int r, input int c, input int n,
                         input int ab, input int bb, input int cb,
                         output int lat, output int rcv);
    clear_log();
    @(negedge clk);
    set_job(r, c, n, ab, bb, cb);
    bus.i_Indexes_Ready = 1'b1;
    @(posedge clk); #1;
    bus.i_Indexes_Ready = 1'b0;
    rcv = bus.o_Indexes_Received ? 1 : 0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.o_Indexes_Received) rcv++;
      if (bus.o_Result_Ready) begin lat = i; break; end
    end
  endtask

  task automatic chk_reads(input string tag, input int exp[$]);
    chk({tag, "_nreads"}, 64'(rd_q.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk(tag, (i < rd_q.size()) ? 64'(rd_q[i]) : 64'hDEAD, 64'(exp[i]));
  endtask

  task automatic chk_write(input string tag, input int addr, input logic [31:0] data);
    chk({tag, "_nwrites"}, 64'(wr_a.size()), 64'd1);
    chk({tag, "_waddr"}, (wr_a.size() > 0) ? 64'(wr_a[0]) : 64'hDEAD, 64'(addr));
    chk({tag, "_wdata"}, (wr_d.size() > 0) ? 64'(wr_d[0]) : 64'hDEAD, 64'(data));
  endtask

  int lat, rcv;
  int exp_rd[$];

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    // A=[[1,2],[3,4]] @0, B=[[5,6],[7,8]] @4, overflow operands @16/17
    mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
    mem[4] = 5; mem[5] = 6; mem[6] = 7; mem[7] = 8;
    mem[16] = 32'hFFFF_FFFF; mem[17] = 32'd2;
    bus.i_Indexes_Ready = 1'b0;
    bus.i_Grant = 1'b1;
    bus.i_Mem_Read_Data = '0;
    set_job(0, 0, 0, 0, 0, 0);

    // reset state
    #12;
    chk("rst_req",   64'(bus.o_Grant_Request), 64'd0);
    chk("rst_rd",    64'(bus.o_Mem_Read), 64'd0);
    chk("rst_wr",    64'(bus.o_Mem_Write), 64'd0);
    chk("rst_addr",  64'(bus.o_Mem_Address), 64'd0);
    chk("rst_rdy",   64'(bus.o_Result_Ready), 64'd0);
    chk("rst_rcvd",  64'(bus.o_Indexes_Received), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // basic product: C[1][0] = 3*5 + 4*7 = 43 -> address 10
    run_job(1, 0, 2, 0, 4, 8, lat, rcv);
    chk("basic_lat", 64'(lat), 64'd8);
    chk("basic_rcvd", 64'(rcv), 64'd1);
    exp_rd = '{2, 4, 3, 6};
    chk_reads("basic_rd", exp_rd);
    chk_write("basic", 10, 32'd43);

    // N=0: single write of 0, no reads
    run_job(1, 0, 0, 0, 4, 20, lat, rcv);
    chk("n0_lat", 64'(lat), 64'd2);
    chk("n0_nreads", 64'(rd_q.size()), 64'd0);
    chk_write("n0", 20, 32'd0);

    // grant dropped for 3 cycles while in READ_B at k=1
    fork
      run_job(1, 0, 2, 0, 4, 8, lat, rcv);
      begin
        @(posedge bus.o_Indexes_Received);
        repeat (5) @(posedge clk);
        #1 bus.i_Grant = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.i_Grant = 1'b1;
      end
    join
    chk("gnt_lat", 64'(lat), 64'd12);
    chk("gnt_badrd", 64'(bad_rd), 64'd0);
    exp_rd = '{2, 4, 3, 3, 6};
    chk_reads("gnt_rd", exp_rd);
    chk_write("gnt", 10, 32'd43);

    // overflow: 0xFFFFFFFF * 2 truncates to 0xFFFFFFFE
    run_job(0, 0, 1, 16, 17, 18, lat, rcv);
    chk("ovf_lat", 64'(lat), 64'd5);
    chk_write("ovf", 18, 32'hFFFF_FFFE);

    // reset while in MAC, then a fresh job
    clear_log();
    @(negedge clk);
    set_job(1, 0, 2, 0, 4, 8);
    bus.i_Indexes_Ready = 1'b1;
    @(posedge clk); #1;
    bus.i_Indexes_Ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_req",  64'(bus.o_Grant_Request), 64'd0);
    chk("mrst_rd",   64'(bus.o_Mem_Read), 64'd0);
    chk("mrst_wr",   64'(bus.o_Mem_Write), 64'd0);
    chk("mrst_addr", 64'(bus.o_Mem_Address), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_rdy",  64'(bus.o_Result_Ready), 64'd0);
    chk("mrst_nowr", 64'(wr_a.size()), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    // C[0][1] = 1*6 + 2*8 = 22 -> address 9
    run_job(0, 1, 2, 0, 4, 8, lat, rcv);
    chk("fresh_lat", 64'(lat), 64'd8);
    chk_write("fresh", 9, 32'd22);

    // Indexes_Ready held across two jobs
    clear_log();
    @(negedge clk);
    set_job(1, 0, 2, 0, 4, 8);
    bus.i_Indexes_Ready = 1'b1;
    @(posedge clk); #1;
    set_job(0, 0, 2, 0, 4, 8);       // second pair, C[0][0] = 5 + 14 = 19
    rcv = 0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.o_Indexes_Received) rcv++;
      if (bus.o_Result_Ready) begin lat = i; break; end
    end
    chk("hold_lat1", 64'(lat), 64'd8);
    chk("hold_rcvd1", 64'(rcv), 64'd0);
    @(posedge clk); #1;
    chk("hold_rdy_fall", 64'(bus.o_Result_Ready), 64'd0);
    chk("hold_rcvd2", 64'(bus.o_Indexes_Received), 64'd1);
    bus.i_Indexes_Ready = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.o_Result_Ready) begin lat = i; break; end
    end
    chk("hold_lat2", 64'(lat), 64'd8);
    chk("hold_nwrites", 64'(wr_a.size()), 64'd2);
    chk("hold_w1", (wr_a.size() > 0) ? {32'(wr_a[0]), wr_d[0]} : 64'hDEAD, {32'd10, 32'd43});
    chk("hold_w2", (wr_a.size() > 1) ? {32'(wr_a[1]), wr_d[1]} : 64'hDEAD, {32'd8, 32'd19});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
